pipeline_latealu: RTL and testbench

- Stage directly downstream of the ALU stage; executes ops the ALU defers: logical/arithmetic right shift, signed multiply, mthi/mtlo.
- Owns the HI/LO registers and feeds them back to the ALU stage for mfhi/mflo.
- Multiply is iterative (8 multiplier bits per cycle), so a busy flag is exported to hazard logic.
- Passes through the ALU stage's writeback fields, with a result override for shift ops.

---
 rtl/pipeline_latealu_pkg.sv | 19 +
 rtl/pipeline_latealu_if.sv | 34 +++
 rtl/pipeline_latealu_mult_iter.sv | 77 +++++++
 rtl/pipeline_latealu.sv | 97 +++++++++
 tb/tb_pipeline_latealu.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_latealu_pkg.sv
// Shared definitions for the late-ALU stage: deferred op encodings, exception
// codes and the iterative multiplier state type.
package pipeline_latealu_pkg;

  localparam logic [5:0] LATEALU_OP_SRL  = 6'b000010;
  localparam logic [5:0] LATEALU_OP_SRA  = 6'b000011;
  localparam logic [5:0] LATEALU_OP_MULT = 6'b000100;
  localparam logic [5:0] LATEALU_OP_MTHI = 6'b000101;
  localparam logic [5:0] LATEALU_OP_MTLO = 6'b000110;

  localparam logic [2:0] EXC_BAD_OP = 3'b001;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_FIN  = 2'd2
  } mult_state_e;

endpackage

// File: rtl/pipeline_latealu_if.sv
// Bus between the ALU stage (master) and the late-ALU stage (slave): writeback
// fields in, deferred op request in, registered writeback and HI/LO out.
interface pipeline_latealu_if;

  logic [4:0]  rd_index_in;
  logic [31:0] rd_value_in;
  logic [2:0]  exception_in;
  logic        latealu_enable;
  logic [5:0]  latealu_op;
  logic [31:0] latealu_a0;
  logic [31:0] latealu_a1;

  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic [2:0]  exception;
  logic [31:0] latealu_mult_hi;
  logic [31:0] latealu_mult_lo;
  logic        mult_busy;

  modport master (
    output rd_index_in, rd_value_in, exception_in,
    output latealu_enable, latealu_op, latealu_a0, latealu_a1,
    input  rd_index, rd_value, exception,
    input  latealu_mult_hi, latealu_mult_lo, mult_busy
  );

  modport slave (
    input  rd_index_in, rd_value_in, exception_in,
    input  latealu_enable, latealu_op, latealu_a0, latealu_a1,
    output rd_index, rd_value, exception,
    output latealu_mult_hi, latealu_mult_lo, mult_busy
  );

endinterface

// File: rtl/pipeline_latealu_mult_iter.sv
// Iterative signed 32x32 multiplier: sign-magnitude, MULT_CHUNK multiplier bits
// per cycle, product presented for one cycle in FIN unless aborted or restarted.
module latealu_mult_iter
  import pipeline_latealu_pkg::*;
#(
  parameter int MULT_CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam int STEPS = 32 / MULT_CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  mult_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     mag0;
  logic [31:0]     mag1;
  logic            neg;
  logic [63:0]     acc;

  logic [5:0]            bit_pos;
  logic [MULT_CHUNK-1:0] chunk;
  logic [63:0]           partial;

  // 0x80000000 negates to itself, which is exactly its magnitude as unsigned.
  function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
    return v[31] ? 32'(-v) : v;
  endfunction

  assign bit_pos = 6'(cnt) * 6'(MULT_CHUNK);
  assign chunk   = MULT_CHUNK'(mag1 >> bit_pos);
  assign partial = (64'(mag0) * 64'(chunk)) << bit_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MULT_IDLE;
      cnt   <= '0;
      mag0  <= '0;
      mag1  <= '0;
      neg   <= 1'b0;
      acc   <= '0;
    end else if (start) begin
      state <= MULT_RUN;
      cnt   <= '0;
      mag0  <= abs_mag(a0);
      mag1  <= abs_mag(a1);
      neg   <= a0[31] ^ a1[31];
      acc   <= '0;
    end else if (abort) begin
      state <= MULT_IDLE;
    end else begin
      case (state)
        MULT_RUN: begin
          acc <= acc + partial;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= MULT_FIN;
        end
        MULT_FIN: state <= MULT_IDLE;
        default:  state <= MULT_IDLE;
      endcase
    end
  end

  assign busy    = (state != MULT_IDLE);
  assign done    = (state == MULT_FIN) && !start && !abort;
  assign product = neg ? -acc : acc;

endmodule

// File: rtl/pipeline_latealu.sv
// Late-ALU stage: registers the ALU writeback, executes deferred shifts,
// mthi/mtlo and iterative multiply, and owns the HI/LO pair.
module pipeline_latealu
  import pipeline_latealu_pkg::*;
#(
  parameter int MULT_CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_latealu_if.slave  bus
);

  logic [4:0]  rd_index_p0;
  logic [31:0] rd_value_p0;
  logic [2:0]  exception_p0;
  logic [31:0] hi_p0;
  logic [31:0] lo_p0;

  logic        mult_start;
  logic        mult_abort;
  logic        mult_busy;
  logic        mult_done;
  logic [63:0] mult_product;

  function automatic logic [31:0] shift_right(input logic [31:0] v,
                                              input logic [4:0]  sh,
                                              input logic        arith);
    logic signed [31:0] sv;
    sv = v;
    return arith ? 32'(sv >>> sh) : (v >> sh);
  endfunction

  assign mult_start = bus.latealu_enable && (bus.latealu_op == LATEALU_OP_MULT);
  assign mult_abort = bus.latealu_enable &&
                      ((bus.latealu_op == LATEALU_OP_MTHI) ||
                       (bus.latealu_op == LATEALU_OP_MTLO));

  latealu_mult_iter #(
    .MULT_CHUNK(MULT_CHUNK)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .abort   (mult_abort),
    .a0      (bus.latealu_a0),
    .a1      (bus.latealu_a1),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  // Stage p0: writeback register plus HI/LO; mthi/mtlo override a FIN write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_index_p0  <= '0;
      rd_value_p0  <= '0;
      exception_p0 <= '0;
      hi_p0        <= '0;
      lo_p0        <= '0;
    end else begin
      rd_index_p0  <= bus.rd_index_in;
      rd_value_p0  <= bus.rd_value_in;
      exception_p0 <= bus.exception_in;
      if (mult_done) {hi_p0, lo_p0} <= mult_product;
      if (bus.latealu_enable) begin
        case (bus.latealu_op)
          LATEALU_OP_SRL:
            rd_value_p0 <= shift_right(bus.latealu_a0, bus.latealu_a1[4:0], 1'b0);
          LATEALU_OP_SRA:
            rd_value_p0 <= shift_right(bus.latealu_a0, bus.latealu_a1[4:0], 1'b1);
          LATEALU_OP_MULT:
            rd_index_p0 <= '0;
          LATEALU_OP_MTHI: begin
            rd_index_p0 <= '0;
            hi_p0       <= bus.latealu_a0;
          end
          LATEALU_OP_MTLO: begin
            rd_index_p0 <= '0;
            lo_p0       <= bus.latealu_a0;
          end
          default: begin
            rd_index_p0  <= '0;
            exception_p0 <= (bus.exception_in == 3'b000) ? EXC_BAD_OP : bus.exception_in;
          end
        endcase
      end
    end
  end

  assign bus.rd_index        = rd_index_p0;
  assign bus.rd_value        = rd_value_p0;
  assign bus.exception       = exception_p0;
  assign bus.latealu_mult_hi = hi_p0;
  assign bus.latealu_mult_lo = lo_p0;
  assign bus.mult_busy       = mult_busy;

endmodule

// File: tb/tb_pipeline_latealu.sv
// Scoreboard bench for pipeline_latealu: stimulus queues expected values with a
// due cycle, a monitor compares them on the falling edge.
module tb_pipeline_latealu;
  import pipeline_latealu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_latealu_if bus();

  pipeline_latealu #(.MULT_CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_RD   = 0;
  localparam int K_HILO = 1;
  localparam int K_BUSY = 2;

  typedef struct {
    int          due;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] rdv(logic [4:0] i, logic [2:0] e, logic [31:0] v);
    return {24'd0, i, e, v};
  endfunction

  function automatic logic [63:0] sample(int kind);
    case (kind)
      K_RD:    return rdv(bus.rd_index, bus.exception, bus.rd_value);
      K_HILO:  return {bus.latealu_mult_hi, bus.latealu_mult_lo};
      default: return {63'd0, bus.mult_busy};
    endcase
  endfunction

  task automatic push(int due, int kind, logic [63:0] v, string n);
    sb.push_back('{due, kind, v, n});
  endtask

  task automatic drive(logic en, logic [5:0] op, logic [31:0] a0, logic [31:0] a1,
                       logic [4:0] idx, logic [31:0] val, logic [2:0] exc);
    bus.latealu_enable = en;
    bus.latealu_op     = op;
    bus.latealu_a0     = a0;
    bus.latealu_a1     = a1;
    bus.rd_index_in    = idx;
    bus.rd_value_in    = val;
    bus.exception_in   = exc;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Disabled mthi request on the bus: must never touch HI.
  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, LATEALU_OP_MTHI, 32'hFFFF0000, 32'h0, 5'd3, 32'hC0DE0000 + k, 3'(k));
      push(cyc + 1, K_RD, rdv(5'd3, 3'(k), 32'hC0DE0000 + k), "idle_pass");
      step();
    end
  endtask

  task automatic shift_chk(string n, logic [5:0] op, logic [31:0] a0, logic [31:0] a1,
                           logic [4:0] idx, logic [2:0] exc, logic [31:0] exp);
    drive(1'b1, op, a0, a1, idx, 32'h1111, exc);
    push(cyc + 1, K_RD, rdv(idx, exc, exp), n);
    step();
  endtask

  task automatic mult_chk(string n, logic [31:0] a0, logic [31:0] a1,
                          logic [63:0] prev, logic [63:0] exp);
    int c;
    c = cyc;
    drive(1'b1, LATEALU_OP_MULT, a0, a1, 5'd9, 32'h2222, 3'd0);
    push(c + 1, K_RD, rdv(5'd0, 3'd0, 32'h2222), {n, "_rd"});
    for (int k = 1; k <= 5; k++) push(c + k, K_BUSY, 64'd1, {n, "_busy"});
    push(c + 6, K_BUSY, 64'd0, {n, "_idle"});
    push(c + 4, K_HILO, prev, {n, "_hold"});
    push(c + 6, K_HILO, exp, {n, "_hilo"});
    step();
    idle(6);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      begin
        int i;
        i = 0;
        while (i < sb.size()) begin
          if (sb[i].due == cyc) begin
            check(sb[i].name, sample(sb[i].kind), sb[i].val);
            sb.delete(i);
          end else begin
            i++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    rst = 1'b1;
    drive(1'b1, LATEALU_OP_MTHI, 32'hFFFFFFFF, 32'h3, 5'd31, 32'hFFFFFFFF, 3'd7);
    repeat (2) @(negedge clk);
    check("reset_rd", sample(K_RD), 64'd0);
    check("reset_hilo", sample(K_HILO), 64'd0);
    check("reset_busy", sample(K_BUSY), 64'd0);
    rst = 1'b0;
    idle(2);

    shift_chk("srl_4", LATEALU_OP_SRL, 32'h80000000, 32'h4, 5'd7, 3'd0, 32'h08000000);
    shift_chk("sra_4", LATEALU_OP_SRA, 32'h80000000, 32'h4, 5'd8, 3'd4, 32'hF8000000);
    shift_chk("srl_hi_bits", LATEALU_OP_SRL, 32'h80000000, 32'hFFFFFFE0, 5'd10, 3'd0, 32'h80000000);
    shift_chk("sra_hi_bits", LATEALU_OP_SRA, 32'h80000000, 32'hFFFFFFE0, 5'd11, 3'd0, 32'h80000000);
    shift_chk("srl_31", LATEALU_OP_SRL, 32'hF0000000, 32'h1F, 5'd12, 3'd0, 32'h00000001);
    shift_chk("sra_pos", LATEALU_OP_SRA, 32'h70000000, 32'h8, 5'd13, 3'd0, 32'h00700000);

    mult_chk("mult_neg", 32'hFFFFFFFE, 32'h00000003, 64'd0, 64'hFFFFFFFF_FFFFFFFA);
    mult_chk("mult_max", 32'h7FFFFFFF, 32'h7FFFFFFF,
             64'hFFFFFFFF_FFFFFFFA, 64'h3FFFFFFF_00000001);
    mult_chk("mult_min", 32'h80000000, 32'h80000000,
             64'h3FFFFFFF_00000001, 64'h40000000_00000000);

    drive(1'b1, LATEALU_OP_MTLO, 32'hAAAA5555, 32'h0, 5'd12, 32'h44, 3'd0);
    push(cyc + 1, K_RD, rdv(5'd0, 3'd0, 32'h44), "mtlo_rd");
    push(cyc + 1, K_HILO, 64'h40000000_AAAA5555, "mtlo_hilo");
    step();

    // mthi lands at E+2 of a running multiply and must cancel its FIN write.
    c = cyc;
    drive(1'b1, LATEALU_OP_MULT, 32'd5, 32'd7, 5'd4, 32'h2222, 3'd0);
    push(c + 1, K_RD, rdv(5'd0, 3'd0, 32'h2222), "abort_mult_rd");
    push(c + 1, K_BUSY, 64'd1, "abort_busy1");
    push(c + 2, K_BUSY, 64'd1, "abort_busy2");
    step();
    idle(1);
    drive(1'b1, LATEALU_OP_MTHI, 32'h12345678, 32'h0, 5'd6, 32'h33, 3'd0);
    push(c + 3, K_RD, rdv(5'd0, 3'd0, 32'h33), "mthi_rd");
    push(c + 3, K_HILO, 64'h12345678_AAAA5555, "mthi_hilo");
    push(c + 3, K_BUSY, 64'd0, "mthi_busy");
    push(c + 6, K_BUSY, 64'd0, "mthi_busy_late");
    push(c + 8, K_HILO, 64'h12345678_AAAA5555, "mthi_no_fin");
    step();
    idle(7);

    // A second mult at E+2 restarts with the new operands.
    c = cyc;
    drive(1'b1, LATEALU_OP_MULT, 32'd2, 32'd3, 5'd9, 32'h2222, 3'd0);
    push(c + 1, K_BUSY, 64'd1, "restart_busy1");
    step();
    idle(1);
    drive(1'b1, LATEALU_OP_MULT, 32'd4, 32'd5, 5'd9, 32'h5555, 3'd0);
    push(c + 3, K_RD, rdv(5'd0, 3'd0, 32'h5555), "restart_rd");
    for (int k = 3; k <= 7; k++) push(c + k, K_BUSY, 64'd1, "restart_busy");
    push(c + 8, K_BUSY, 64'd0, "restart_idle");
    push(c + 6, K_HILO, 64'h12345678_AAAA5555, "restart_hold6");
    push(c + 7, K_HILO, 64'h12345678_AAAA5555, "restart_hold7");
    push(c + 8, K_HILO, 64'd20, "restart_hilo");
    step();
    idle(7);

    drive(1'b1, 6'b000111, 32'h1, 32'h2, 5'd13, 32'h55, 3'd0);
    push(cyc + 1, K_RD, rdv(5'd0, EXC_BAD_OP, 32'h55), "bad_op_exc0");
    step();
    drive(1'b1, 6'b000111, 32'h1, 32'h2, 5'd14, 32'h66, 3'b010);
    push(cyc + 1, K_RD, rdv(5'd0, 3'b010, 32'h66), "bad_op_exc2");
    push(cyc + 1, K_HILO, 64'd20, "bad_op_hilo");
    step();

    // Asynchronous reset while a multiply is running, checked between edges.
    drive(1'b1, LATEALU_OP_MTHI, 32'h0BADF00D, 32'h0, 5'd2, 32'h77, 3'd0);
    push(cyc + 1, K_HILO, 64'h0BADF00D_00000014, "pre_rst_mthi");
    step();
    c = cyc;
    drive(1'b1, LATEALU_OP_MULT, 32'd3, 32'd5, 5'd9, 32'h2222, 3'd0);
    push(c + 1, K_BUSY, 64'd1, "rst_mid_busy1");
    push(c + 2, K_BUSY, 64'd1, "rst_mid_busy2");
    step();
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_hilo", sample(K_HILO), 64'd0);
    check("rst_mid_busy", sample(K_BUSY), 64'd0);
    check("rst_mid_rd", sample(K_RD), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    repeat (2) @(negedge clk);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
